instruction_loader: RTL and testbench

Program loader for the instruction memory: receives a little-endian byte stream over a valid/ready handshake, assembles 32-bit instruction words, and writes them to consecutive word addresses through the instruction memory's write port. It sits between the host/boot byte source and the instruction memory. It is the write-side counterpart of the processor's combinational, word-indexed fetch path. While `Busy` is high, the processor is held in reset by the top level.

---
 rtl/loader_pkg.sv | 14 +
 rtl/instruction_loader_if.sv | 27 ++
 rtl/byte_assembler.sv | 48 ++++
 rtl/instruction_loader.sv | 108 ++++++++++
 tb/tb_instruction_loader.sv | 334 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction loader and its byte assembler.
package loader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam int BYTES_PER_WORD = 4;
    localparam int CNT_WIDTH      = $clog2(BYTES_PER_WORD);

endpackage

// File: rtl/instruction_loader_if.sv
// Host-side byte stream and instruction-memory write port of the loader.
// The master is the host/boot side; the slave is the loader itself.
interface instruction_loader_if #(
    parameter int LEN_WIDTH = 4
);
    logic                 Start;
    logic [LEN_WIDTH-1:0] Length;
    logic [7:0]           ByteIn;
    logic                 ByteValid;
    logic                 ByteReady;
    logic                 WriteEnable;
    logic [31:0]          WriteAddress;
    logic [31:0]          WriteData;
    logic                 Busy;
    logic                 Done;
    logic                 Error;

    modport master (
        output Start, Length, ByteIn, ByteValid,
        input  ByteReady, WriteEnable, WriteAddress, WriteData, Busy, Done, Error
    );

    modport slave (
        input  Start, Length, ByteIn, ByteValid,
        output ByteReady, WriteEnable, WriteAddress, WriteData, Busy, Done, Error
    );
endinterface

// File: rtl/byte_assembler.sv
// Collects little-endian bytes into a 32-bit word. `word` already includes the
// byte offered this cycle, so the caller can capture a complete word on the
// same edge that accepts its last byte.
module byte_assembler
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clear,
    input  logic        accept,
    input  logic [7:0]  ByteIn,
    output logic [31:0] word,
    output logic        word_full
);

    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [23:0]          shift_q, shift_d;   // last three accepted bytes

    // Bytes enter at the top and move down, so the first byte ends up in the LSB.
    assign word      = {ByteIn, shift_q};
    assign word_full = accept && (cnt_q == CNT_WIDTH'(BYTES_PER_WORD - 1));

    // Next byte count and shift contents.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
        cnt_d   = cnt_q;
        shift_d = shift_q;
        if (clear) begin
            cnt_d = '0;
        end else if (accept) begin
            cnt_d   = cnt_q + CNT_WIDTH'(1);
            shift_d = word[31:8];
        end
    end

    // Byte count and shift register, synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!reset_n) begin
            cnt_q   <= '0;
            shift_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
        end
    end

endmodule

// File: rtl/instruction_loader.sv
// Program loader: turns a byte stream into 32-bit words written to consecutive
// instruction-memory word addresses. Outputs are registered or decoded from the
// state register, so no input reaches an output combinationally.
module instruction_loader
    import loader_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int LEN_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    instruction_loader_if.slave  bus
);

    state_e               state_q, state_d;
    logic [LEN_WIDTH-1:0] idx_q, idx_d;       // word index of the word being assembled
    logic [LEN_WIDTH-1:0] len_q, len_d;       // latched word count
    logic [31:0]          addr_q, addr_d;
    logic [31:0]          data_q, data_d;
    logic                 error_q, error_d;

    logic                 asm_clear;
    logic                 asm_accept;
    logic                 asm_full;
    logic [31:0]          asm_word;
    logic                 len_ok;

    assign len_ok = (bus.Length != '0) && (bus.Length <= LEN_WIDTH'(DEPTH));

    byte_assembler u_asm (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (asm_clear),
        .accept    (asm_accept),
        .ByteIn    (bus.ByteIn),
        .word      (asm_word),
        .word_full (asm_full)
    );

    // Next state, counters and captured write word/address.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        len_d      = len_q;
        addr_d     = addr_q;
        data_d     = data_q;
        error_d    = 1'b0;
        asm_clear  = 1'b0;
        asm_accept = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.Start) begin
                    if (len_ok) begin
                        len_d     = bus.Length;
                        idx_d     = '0;
                        asm_clear = 1'b1;
                        state_d   = LOAD;
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end
            LOAD: begin
                asm_accept = bus.ByteValid;
                if (asm_full) begin
                    addr_d  = 32'(idx_q);
                    data_d  = asm_word;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                idx_d     = idx_q + LEN_WIDTH'(1);
                asm_clear = 1'b1;
                state_d   = (idx_d == len_q) ? DONE : LOAD;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and output registers, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            len_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            error_q <= error_d;
        end
    end

    assign bus.ByteReady    = (state_q == LOAD);
    assign bus.WriteEnable  = (state_q == WRITE);
    assign bus.Busy         = (state_q == LOAD) || (state_q == WRITE);
    assign bus.Done         = (state_q == DONE);
    assign bus.Error        = error_q;
    assign bus.WriteAddress = addr_q;
    assign bus.WriteData    = data_q;

endmodule

// File: tb/tb_instruction_loader.sv
// Bench for instruction_loader: randomized byte streams checked against a
// word-packing reference model, plus the directed corner cases.
module tb_instruction_loader;

    typedef logic [7:0] byte_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   start_cyc = 0;

    // Observations collected by the monitor (absolute cycle numbers).
    logic [31:0] got_addr[$];
    logic [31:0] got_data[$];
    int          got_cyc[$];
    int          done_cnt = 0;
    int          done_cyc = 0;
    int          err_cnt = 0;
    int          busy_cnt = 0;
    int          rdy_viol = 0;

    instruction_loader_if #(.LEN_WIDTH(4)) bus ();

    instruction_loader #(.DEPTH(8), .LEN_WIDTH(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Sample outputs mid-cycle.
    always @(negedge clk) begin
        if (bus.WriteEnable === 1'b1) begin
            got_addr.push_back(bus.WriteAddress);
            got_data.push_back(bus.WriteData);
            got_cyc.push_back(cyc);
            if (bus.ByteReady !== 1'b0) rdy_viol++;
        end
        if (bus.Done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (bus.Error === 1'b1) err_cnt++;
        if (bus.Busy === 1'b1) busy_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: word w is bytes 4w..4w+3 with the first byte as LSB.
    function automatic logic [31:0] model_word(input byte_t b[$], input int w);
        return 32'(b[4*w]) + (32'(b[4*w+1]) << 8) + (32'(b[4*w+2]) << 16) + (32'(b[4*w+3]) << 24);
    endfunction

    function automatic int spec_cycle(input int abs_cyc);
        return abs_cyc - start_cyc + 1;
    endfunction

    task automatic begin_load(input logic [3:0] len);
        bus.Start  = 1'b1;
        bus.Length = len;
        @(posedge clk); #1;
        start_cyc = cyc;
        bus.Start = 1'b0;
    endtask

    // Offer bytes in order; a byte is consumed only when offered while ready.
    task automatic drive_bytes(input byte_t q[$], input int stall_pct, input int start_at, output bit ok);
        int  i = 0;
        int  it = 0;
        logic v;
        logic rdy;
        while (i < q.size() && it < 1000) begin
            bus.ByteIn    = q[i];
            v             = ($urandom_range(99) >= stall_pct);
            bus.ByteValid = v;
            bus.Start     = (it == start_at);
            bus.Length    = 4'd1;
            rdy           = bus.ByteReady;
            @(posedge clk); #1;
            if (v && rdy) i++;
            it++;
        end
        bus.ByteValid = 1'b0;
        bus.Start     = 1'b0;
        bus.ByteIn    = $urandom();
        ok = (i == q.size());
    endtask

    task automatic wait_done(input int target, output bit ok);
        int g = 0;
        while (done_cnt < target && g < 100) begin
            @(posedge clk); #1;
            g++;
        end
        ok = (done_cnt >= target);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.Start = 1'b0; bus.Length = '0; bus.ByteIn = '0; bus.ByteValid = 1'b0;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if ({bus.ByteReady, bus.WriteEnable, bus.Busy, bus.Done, bus.Error} !== 5'b0) begin
            bad++;
            $display("FAIL reset_flags: got %b want 00000",
                     {bus.ByteReady, bus.WriteEnable, bus.Busy, bus.Done, bus.Error});
        end
        total++;
        if (bus.WriteAddress !== 32'd0 || bus.WriteData !== 32'd0) begin
            bad++;
            $display("FAIL reset_bus: addr=%h data=%h want 0/0", bus.WriteAddress, bus.WriteData);
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_single_word();
        byte_t q[$] = '{8'h04, 8'h00, 8'hA0, 8'hE3};
        int  bw = got_addr.size();
        int  bd = done_cnt;
        int  bb = busy_cnt;
        bit  ok_b, ok_d;
        begin_load(4'd1);
        drive_bytes(q, 0, -1, ok_b);
        wait_done(bd + 1, ok_d);
        total++;
        if (!(ok_b && ok_d)) begin bad++; $display("FAIL single_timeout: bytes_ok=%0d done_ok=%0d want 1/1", ok_b, ok_d); end
        total++;
        if (got_addr.size() - bw != 1) begin
            bad++; $display("FAIL single_count: got %0d writes want 1", got_addr.size() - bw);
        end else begin
            total++;
            if (got_addr[bw] !== 32'd0) begin bad++; $display("FAIL single_addr: got %h want 0", got_addr[bw]); end
            total++;
            if (got_data[bw] !== 32'hE3A00004) begin bad++; $display("FAIL single_data: got %h want e3a00004", got_data[bw]); end
            total++;
            if (spec_cycle(got_cyc[bw]) != 5) begin bad++; $display("FAIL single_we_cycle: got %0d want 5", spec_cycle(got_cyc[bw])); end
        end
        total++;
        if (spec_cycle(done_cyc) != 6) begin bad++; $display("FAIL single_done_cycle: got %0d want 6", spec_cycle(done_cyc)); end
        total++;
        if (busy_cnt - bb != 5) begin bad++; $display("FAIL single_busy: got %0d cycles want 5", busy_cnt - bb); end
        total++;
        if (done_cnt - bd != 1) begin bad++; $display("FAIL single_done_count: got %0d want 1", done_cnt - bd); end
    endtask

    task automatic test_full_load();
        byte_t q[$];
        int  bw = got_addr.size();
        int  bd = done_cnt;
        int  bb = busy_cnt;
        bit  ok_b, ok_d;
        for (int i = 0; i < 32; i++) q.push_back(byte_t'(i));
        begin_load(4'd8);
        drive_bytes(q, 0, -1, ok_b);
        wait_done(bd + 1, ok_d);
        total++;
        if (!(ok_b && ok_d)) begin bad++; $display("FAIL full_timeout: bytes_ok=%0d done_ok=%0d want 1/1", ok_b, ok_d); end
        total++;
        if (got_addr.size() - bw != 8) begin
            bad++; $display("FAIL full_count: got %0d writes want 8", got_addr.size() - bw);
        end else begin
            for (int w = 0; w < 8; w++) begin
                total++;
                if (got_addr[bw+w] !== 32'(w) || got_data[bw+w] !== model_word(q, w)) begin
                    bad++;
                    $display("FAIL full_word%0d: got addr=%h data=%h want addr=%h data=%h",
                             w, got_addr[bw+w], got_data[bw+w], 32'(w), model_word(q, w));
                end
            end
            total++;
            if (got_data[bw] !== 32'h03020100 || got_data[bw+7] !== 32'h1F1E1D1C) begin
                bad++; $display("FAIL full_ends: got %h/%h want 03020100/1f1e1d1c", got_data[bw], got_data[bw+7]);
            end
        end
        total++;
        if (spec_cycle(done_cyc) != 41) begin bad++; $display("FAIL full_done_cycle: got %0d want 41", spec_cycle(done_cyc)); end
        total++;
        if (busy_cnt - bb != 40) begin bad++; $display("FAIL full_busy: got %0d cycles want 40", busy_cnt - bb); end
    endtask

    task automatic test_stalls();
        for (int iter = 0; iter < 4; iter++) begin
            byte_t q[$];
            int  len = (iter == 0) ? 2 : $urandom_range(1, 8);
            int  bw = got_addr.size();
            int  bd = done_cnt;
            int  bv = rdy_viol;
            bit  ok_b, ok_d;
            for (int i = 0; i < 4 * len; i++) q.push_back(byte_t'($urandom()));
            begin_load(4'(len));
            drive_bytes(q, 50, -1, ok_b);
            wait_done(bd + 1, ok_d);
            total++;
            if (!(ok_b && ok_d)) begin bad++; $display("FAIL stall%0d_timeout: bytes_ok=%0d done_ok=%0d want 1/1", iter, ok_b, ok_d); end
            total++;
            if (got_addr.size() - bw != len) begin
                bad++; $display("FAIL stall%0d_count: got %0d writes want %0d", iter, got_addr.size() - bw, len);
            end else begin
                for (int w = 0; w < len; w++) begin
                    total++;
                    if (got_addr[bw+w] !== 32'(w) || got_data[bw+w] !== model_word(q, w)) begin
                        bad++;
                        $display("FAIL stall%0d_word%0d: got addr=%h data=%h want addr=%h data=%h",
                                 iter, w, got_addr[bw+w], got_data[bw+w], 32'(w), model_word(q, w));
                    end
                end
            end
            total++;
            if (rdy_viol != bv) begin bad++; $display("FAIL stall%0d_ready_in_write: got %0d want 0", iter, rdy_viol - bv); end
            total++;
            if (done_cnt - bd != 1) begin bad++; $display("FAIL stall%0d_done_count: got %0d want 1", iter, done_cnt - bd); end
        end
    endtask

    task automatic test_invalid_length();
        logic [3:0] lens[3];
        lens[0] = 4'd0;
        lens[1] = 4'd9;
        lens[2] = 4'($urandom_range(10, 15));
        for (int k = 0; k < 3; k++) begin
            int be = err_cnt;
            int bb = busy_cnt;
            int bw = got_addr.size();
            begin_load(lens[k]);
            repeat (4) @(posedge clk);
            #1;
            total++;
            if (err_cnt - be != 1) begin bad++; $display("FAIL invalid_len%0d_error: got %0d pulses want 1", lens[k], err_cnt - be); end
            total++;
            if (busy_cnt != bb || got_addr.size() != bw) begin
                bad++; $display("FAIL invalid_len%0d_idle: busy=%0d writes=%0d want 0/0", lens[k], busy_cnt - bb, got_addr.size() - bw);
            end
        end
    endtask

    task automatic test_reset_mid_load();
        byte_t q[$];
        byte_t q2[$];
        int  bw = got_addr.size();
        int  bd = done_cnt;
        bit  ok_b, ok_d;
        for (int i = 0; i < 6; i++) q.push_back(byte_t'($urandom()));
        begin_load(4'd2);
        drive_bytes(q, 0, -1, ok_b);
        reset_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        total++;
        if ({bus.ByteReady, bus.WriteEnable, bus.Busy, bus.Done, bus.Error} !== 5'b0 ||
            bus.WriteAddress !== 32'd0 || bus.WriteData !== 32'd0) begin
            bad++;
            $display("FAIL midreset_outputs: flags=%b addr=%h data=%h want 00000/0/0",
                     {bus.ByteReady, bus.WriteEnable, bus.Busy, bus.Done, bus.Error}, bus.WriteAddress, bus.WriteData);
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        total++;
        if (!ok_b || got_addr.size() - bw != 1 || done_cnt != bd) begin
            bad++; $display("FAIL midreset_writes: got %0d writes %0d done want 1 write 0 done", got_addr.size() - bw, done_cnt - bd);
        end
        for (int i = 0; i < 4; i++) q2.push_back(byte_t'($urandom()));
        bw = got_addr.size();
        begin_load(4'd1);
        drive_bytes(q2, 0, -1, ok_b);
        wait_done(bd + 1, ok_d);
        total++;
        if (got_addr.size() - bw != 1 || !ok_d) begin
            bad++; $display("FAIL midreset_reload_count: got %0d writes done_ok=%0d want 1/1", got_addr.size() - bw, ok_d);
        end else if (got_addr[bw] !== 32'd0 || got_data[bw] !== model_word(q2, 0)) begin
            bad++; $display("FAIL midreset_reload_word: got addr=%h data=%h want 0/%h", got_addr[bw], got_data[bw], model_word(q2, 0));
        end
    endtask

    task automatic test_start_while_busy();
        byte_t q[$];
        int  bw = got_addr.size();
        int  bd = done_cnt;
        int  be = err_cnt;
        bit  ok_b, ok_d;
        for (int i = 0; i < 12; i++) q.push_back(byte_t'($urandom()));
        begin_load(4'd3);
        drive_bytes(q, 20, $urandom_range(1, 12), ok_b);
        wait_done(bd + 1, ok_d);
        repeat (10) @(posedge clk);
        #1;
        total++;
        if (!(ok_b && ok_d) || done_cnt - bd != 1 || err_cnt != be) begin
            bad++; $display("FAIL busy_start_done: got %0d done %0d error want 1/0", done_cnt - bd, err_cnt - be);
        end
        total++;
        if (got_addr.size() - bw != 3) begin
            bad++; $display("FAIL busy_start_count: got %0d writes want 3", got_addr.size() - bw);
        end else begin
            for (int w = 0; w < 3; w++) begin
                total++;
                if (got_addr[bw+w] !== 32'(w) || got_data[bw+w] !== model_word(q, w)) begin
                    bad++;
                    $display("FAIL busy_start_word%0d: got addr=%h data=%h want addr=%h data=%h",
                             w, got_addr[bw+w], got_data[bw+w], 32'(w), model_word(q, w));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_full_load();
        test_stalls();
        test_invalid_length();
        test_reset_mid_load();
        test_start_while_busy();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
